register_file_2r1w: RTL and testbench

//  General-purpose register file for the 16-bit datapath: 16 x 16-bit registers.
//  Two combinational read ports (A1->RD1, A2->RD2), one synchronous write port (A3/WD3/regWrite).

---
 rtl/regfile_pkg.sv | 12 +
 rtl/regfile_read_port.sv | 26 ++
 rtl/register_file_2r1w.sv | 63 ++++++
 tb/tb_register_file_2r1w.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared sizes and types for the 16 x 16-bit two-read/one-write register file.
// Optional feature macro: REGFILE_WRITE_BYPASS_EN (write-through forwarding to read ports).
package regfile_pkg;

  localparam int DATA_W   = 16;
  localparam int ADDR_W   = 4;
  localparam int NUM_REGS = 2 ** ADDR_W;

  typedef logic [DATA_W-1:0] data_t;
  typedef logic [ADDR_W-1:0] addr_t;

endpackage

// File: rtl/regfile_read_port.sv
// One combinational read port: address-to-data mux over the register array.
// With REGFILE_WRITE_BYPASS_EN defined, an in-flight write to the same address is forwarded.
module regfile_read_port
  import regfile_pkg::*;
(
  input  addr_t rd_addr_i,
`ifdef REGFILE_WRITE_BYPASS_EN
  input  logic  wr_en_i,
  input  addr_t wr_addr_i,
  input  data_t wr_data_i,
`endif
  input  data_t regs_i [NUM_REGS],
  output data_t rd_data_o
);

  always_comb begin
    rd_data_o = regs_i[rd_addr_i];
`ifdef REGFILE_WRITE_BYPASS_EN
    // wr_en_i is already qualified with reset by the parent, so forwarding never leaks during reset.
    if (wr_en_i && (wr_addr_i == rd_addr_i)) begin
      rd_data_o = wr_data_i;
    end
`endif
  end

endmodule

// File: rtl/register_file_2r1w.sv
// 16 x 16-bit register file: two combinational read ports, one synchronous write port.
// Optional feature macro: REGFILE_WRITE_BYPASS_EN (same-cycle write-to-read forwarding).
module register_file_2r1w
  import regfile_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              regWrite,
  input  logic [ADDR_W-1:0] A1,
  input  logic [ADDR_W-1:0] A2,
  input  logic [ADDR_W-1:0] A3,
  input  logic [DATA_W-1:0] WD3,
  output logic [DATA_W-1:0] RD1,
  output logic [DATA_W-1:0] RD2
);

  // No handshake: a write is taken on every rising edge where regWrite=1 and rst=0.
  data_t regs_q [NUM_REGS];
  data_t regs_d [NUM_REGS];

  always_comb begin
    regs_d = regs_q;
    if (regWrite) begin
      regs_d[A3] = WD3;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regs_q <= '{default: '0};
    end else begin
      regs_q <= regs_d;
    end
  end

`ifdef REGFILE_WRITE_BYPASS_EN
  logic wr_fwd_en;
  assign wr_fwd_en = regWrite & ~rst;
`endif

  regfile_read_port u_read_port_1 (
    .rd_addr_i (A1),
`ifdef REGFILE_WRITE_BYPASS_EN
    .wr_en_i   (wr_fwd_en),
    .wr_addr_i (A3),
    .wr_data_i (WD3),
`endif
    .regs_i    (regs_q),
    .rd_data_o (RD1)
  );

  regfile_read_port u_read_port_2 (
    .rd_addr_i (A2),
`ifdef REGFILE_WRITE_BYPASS_EN
    .wr_en_i   (wr_fwd_en),
    .wr_addr_i (A3),
    .wr_data_i (WD3),
`endif
    .regs_i    (regs_q),
    .rd_data_o (RD2)
  );

endmodule

// File: tb/tb_register_file_2r1w.sv
// Directed self-checking bench for register_file_2r1w (both macro settings).
module tb_register_file_2r1w;

  logic        clk;
  logic        rst;
  logic        regWrite;
  logic [3:0]  A1;
  logic [3:0]  A2;
  logic [3:0]  A3;
  logic [15:0] WD3;
  logic [15:0] RD1;
  logic [15:0] RD2;

  int checks = 0;
  int errors = 0;

  register_file_2r1w dut (
    .clk      (clk),
    .rst      (rst),
    .regWrite (regWrite),
    .A1       (A1),
    .A2       (A2),
    .A3       (A3),
    .WD3      (WD3),
    .RD1      (RD1),
    .RD2      (RD2)
  );

  // Clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL timeout observed=running required=finished");
    $fatal(1, "simulation time limit reached");
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_reg(input logic [3:0] addr, input logic [15:0] data);
    regWrite = 1'b1;
    A3       = addr;
    WD3      = data;
    tick();
    regWrite = 1'b0;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] fill_val(input int i);
    return ~(16'h1111 * 16'(i));
  endfunction

  initial begin
    rst = 1'b1; regWrite = 1'b0; A1 = 4'd0; A2 = 4'd1; A3 = 4'd0; WD3 = 16'h0000;
    #2;
    check("reset_rd1", RD1, 16'h0000);
    check("reset_rd2", RD2, 16'h0000);

    // Writes are ignored under reset; A1==A3 also shows no forwarding during reset.
    regWrite = 1'b1; A3 = 4'd0; WD3 = 16'h1234;
    tick(); tick();
    check("reset_write_ignored_rd1", RD1, 16'h0000);
    check("reset_write_ignored_rd2", RD2, 16'h0000);

    rst = 1'b0;
    write_reg(4'd0, 16'h2222);
    write_reg(4'd1, 16'hFF00);
    A1 = 4'd0; A2 = 4'd1; #1;
    check("basic_r0", RD1, 16'h2222);
    check("basic_r1", RD2, 16'hFF00);

    regWrite = 1'b0; A3 = 4'd1; WD3 = 16'hAAAA;
    tick(); tick(); tick();
    check("hold_no_we_r1", RD2, 16'hFF00);
    check("hold_no_we_r0", RD1, 16'h2222);

    write_reg(4'd15, 16'h5A5A);
    A1 = 4'd15; A2 = 4'd15; #1;
    check("r15_port1", RD1, 16'h5A5A);
    check("r15_port2", RD2, 16'h5A5A);
    A1 = 4'd0; A2 = 4'd1; #1;
    check("r0_untouched", RD1, 16'h2222);
    check("r1_untouched", RD2, 16'hFF00);

    // Fill r2..r14 and read every register back on both ports in opposite order.
    for (int i = 2; i < 15; i++) write_reg(4'(i), fill_val(i));
    for (int i = 0; i < 16; i++) begin
      logic [15:0] e1, e2;
      A1 = 4'(i); A2 = 4'(15 - i); #1;
      e1 = (i == 0) ? 16'h2222 : (i == 1) ? 16'hFF00 : (i == 15) ? 16'h5A5A : fill_val(i);
      e2 = (i == 15) ? 16'h2222 : (i == 14) ? 16'hFF00 : (i == 0) ? 16'h5A5A : fill_val(15 - i);
      check($sformatf("sweep_rd1_r%0d", i), RD1, e1);
      check($sformatf("sweep_rd2_r%0d", 15 - i), RD2, e2);
    end

    // Same-address read/write before the edge (port 1), then port 2.
    tick();
    regWrite = 1'b1; A3 = 4'd3; WD3 = 16'hBEEF; A1 = 4'd3; A2 = 4'd4; #1;
`ifdef REGFILE_WRITE_BYPASS_EN
    check("raw_pre_edge_rd1", RD1, 16'hBEEF);
`else
    check("raw_pre_edge_rd1", RD1, fill_val(3));
`endif
    check("raw_pre_edge_other", RD2, fill_val(4));
    tick();
    regWrite = 1'b0; A2 = 4'd3; #1;
    check("raw_post_edge_rd1", RD1, 16'hBEEF);
    check("raw_post_edge_rd2", RD2, 16'hBEEF);

    regWrite = 1'b1; A3 = 4'd5; WD3 = 16'hC0DE; A1 = 4'd3; A2 = 4'd5; #1;
`ifdef REGFILE_WRITE_BYPASS_EN
    check("raw2_pre_edge_rd2", RD2, 16'hC0DE);
`else
    check("raw2_pre_edge_rd2", RD2, fill_val(5));
`endif
    check("raw2_pre_edge_rd1", RD1, 16'hBEEF);
    tick();
    regWrite = 1'b0; #1;
    check("raw2_post_edge_rd2", RD2, 16'hC0DE);

    // Asynchronous reset pulse between edges clears everything without a clock.
    #1;
    rst = 1'b1; A1 = 4'd15; A2 = 4'd0; #1;
    check("async_rst_r15", RD1, 16'h0000);
    check("async_rst_r0", RD2, 16'h0000);
    A1 = 4'd3; A2 = 4'd5; #1;
    check("async_rst_r3", RD1, 16'h0000);
    check("async_rst_r5", RD2, 16'h0000);

    // Reset held across an edge with regWrite=1: no write happens.
    regWrite = 1'b1; A3 = 4'd2; WD3 = 16'h7777; A1 = 4'd2; A2 = 4'd0;
    tick();
    check("rst_beats_write", RD1, 16'h0000);

    // Releasing reset mid-cycle does not write until the next edge.
    rst = 1'b0; #1;
`ifdef REGFILE_WRITE_BYPASS_EN
    check("rst_release_pre_edge", RD1, 16'h7777);
`else
    check("rst_release_pre_edge", RD1, 16'h0000);
`endif
    check("rst_release_other", RD2, 16'h0000);
    tick();
    regWrite = 1'b0; #1;
    check("rst_release_post_edge", RD1, 16'h7777);
    check("rst_release_r0_zero", RD2, 16'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
